// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..9 data bits, optional parity, 1 or 2 stop bits,
// 3-sample majority vote per bit, parity/framing/break reporting alongside each word.
module uart_rx_cfg #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);

  localparam logic [CntW-1:0] CntHalf     = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] CntSamp     = CntW'(CLKS_PER_BIT - 3);
  localparam logic [CntW-1:0] CntLast     = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxDataLast = IdxW'(DATA_BITS - 1);
  localparam logic [IdxW-1:0] IdxStopLast = IdxW'(STOP_BITS - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StParity   = 3'd3;
  localparam logic [2:0] StStop     = 3'd4;
  localparam logic [2:0] StDone     = 3'd5;
  localparam logic [2:0] StWaitIdle = 3'd6;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [CntW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 dv_q, dv_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 brk_q, brk_d;
  logic                 bit_tick;
  logic                 vote;

  assign rx_s     = sync_q[1];
  assign bit_tick = (clk_cnt_q == CntLast);
  // samp_q[1] taken at CntSamp, samp_q[0] one cycle later, rx_s is the third sample
  assign vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_idx_d    = bit_idx_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    dv_d         = 1'b0;
    byte_d       = byte_q;
    perr_out_d   = 1'b0;
    ferr_out_d   = 1'b0;
    brk_d        = 1'b0;

    if (state_q == StData || state_q == StParity || state_q == StStop) begin
      if (clk_cnt_q >= CntSamp && !bit_tick) samp_d = {samp_q[0], rx_s};
      clk_cnt_d = bit_tick ? '0 : clk_cnt_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        clk_cnt_d    = '0;
        bit_idx_d    = '0;
        par_bit_d    = 1'b0;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (clk_cnt_q == CntHalf) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? StIdle : StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      StData: begin
        if (bit_tick) begin
          for (int k = 0; k < int'(DATA_BITS); k++) begin
            if (bit_idx_q == IdxW'(k)) shift_d[k] = vote;
          end
          if (bit_idx_q == IdxDataLast) begin
            bit_idx_d = '0;
            state_d   = (PARITY_EN != 0) ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          par_bit_d    = vote;
          parity_err_d = vote ^ (^shift_q) ^ (PARITY_ODD != 0);
          state_d      = StStop;
        end
      end
      StStop: begin
        if (bit_tick) begin
          frame_err_d = frame_err_q | ~vote;
          if (bit_idx_q == IdxStopLast) begin
            bit_idx_d  = '0;
            state_d    = StDone;
            dv_d       = 1'b1;
            byte_d     = shift_q;
            perr_out_d = parity_err_q & (PARITY_EN != 0);
            ferr_out_d = frame_err_d;
            brk_d      = (shift_q == '0) & ~par_bit_q & frame_err_d;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StDone:     state_d = frame_err_q ? StWaitIdle : StIdle;
      // A held-low break line must not retrigger a frame
      StWaitIdle: if (rx_s) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync_q       <= 2'b11;
      state_q      <= StIdle;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      samp_q       <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      dv_q         <= 1'b0;
      byte_q       <= '0;
      perr_out_q   <= 1'b0;
      ferr_out_q   <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], i_Rx_Serial};
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      dv_q         <= dv_d;
      byte_q       <= byte_d;
      perr_out_q   <= perr_out_d;
      ferr_out_q   <= ferr_out_d;
      brk_q        <= brk_d;
    end
  end

  assign o_Rx_DV      = dv_q;
  assign o_Rx_Byte    = byte_q;
  assign o_Parity_Err = perr_out_q;
  assign o_Frame_Err  = ferr_out_q;
  assign o_Break      = brk_q;
  assign o_Busy       = (state_q != StIdle);

endmodule
